hockey_game_ctrl: RTL

//  Game-flow sequencer for the air-hockey FPGA: owns the match FSM, puck motion, paddle collision and scoring.

---
 rtl/game_pkg.sv | 31 +++
 rtl/move_tick_gen.sv | 30 +++
 rtl/hockey_game_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the air-hockey game controller: FSM states,
// display-facing game-state codes and playfield geometry.
package game_pkg;

  typedef enum logic [1:0] {
    ST_INTRO = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [1:0] GS_INTRO = 2'd0;
  localparam logic [1:0] GS_PLAY  = 2'd1;
  localparam logic [1:0] GS_END   = 2'd2;

  localparam logic [3:0] X_MIN = 4'd1;
  localparam logic [3:0] X_MAX = 4'd14;
  localparam logic [3:0] X_CTR = 4'd7;
  localparam logic [2:0] Y_MAX = 3'd7;
  localparam logic [2:0] Y_CTR = 3'd3;

  // SERVE and PLAY look the same to the display, so both report GS_PLAY.
  function automatic logic [1:0] gs_decode(input state_t s);
    case (s)
      ST_INTRO: return GS_INTRO;
      ST_END:   return GS_END;
      default:  return GS_PLAY;
    endcase
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Puck move-rate divider: emits a one-cycle mv pulse every TICK_DIV
// cycles while enabled, and sits at zero whenever disabled.
module move_tick_gen #(
  parameter int TICK_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mv
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 while enabled; dropping en restarts the period.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign mv = en & (cnt == LAST);

endmodule

// File: rtl/hockey_game_ctrl.sv
// Air-hockey match sequencer: intro/serve/play/end flow, puck motion with
// wall and paddle reflection, goal detection and scoring.
module hockey_game_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 2_500_000,
  parameter int SERVE_HOLD = 4,
  parameter int WIN_SCORE  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic [7:0] lplate,
  input  logic [7:0] rplate,
  output logic [1:0] gamestate,
  output logic [3:0] x,
  output logic [2:0] y,
  output logic [6:0] lscore,
  output logic [6:0] rscore,
  output logic       score_evt
);

  localparam logic [6:0] WIN7      = 7'(WIN_SCORE);
  localparam logic [7:0] HOLD_LAST = 8'(SERVE_HOLD - 1);

  state_t     state;
  logic       start_q;
  logic       start_rise;
  logic       mv;
  logic       dx_neg;
  logic       dy_neg;
  logic [7:0] hold;

  logic       dx_nxt;
  logic       dy_nxt;
  logic       l_miss;
  logic       r_miss;
  logic [3:0] x_step;
  logic [2:0] y_step;

  assign start_rise = start_btn & ~start_q;
  assign gamestate  = gs_decode(state);

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state == ST_SERVE) || (state == ST_PLAY)),
    .mv    (mv)
  );

  // One move step from the current puck position: wall bounce, then goal-line paddle check, then advance.
  always_comb begin
    dy_nxt = dy_neg;
    if ((y == Y_MAX && !dy_neg) || (y == 3'd0 && dy_neg)) begin
      dy_nxt = ~dy_neg;
    end
    dx_nxt = dx_neg;
    l_miss = 1'b0;
    r_miss = 1'b0;
    if (x == X_MIN && dx_neg) begin
      if (lplate[y]) dx_nxt = 1'b0;
      else           l_miss = 1'b1;
    end
    if (x == X_MAX && !dx_neg) begin
      if (rplate[y]) dx_nxt = 1'b1;
      else           r_miss = 1'b1;
    end
    x_step = dx_nxt ? (x - 4'd1) : (x + 4'd1);
    y_step = dy_nxt ? (y - 3'd1) : (y + 3'd1);
  end

  // Match FSM owning puck position, direction, serve hold and both scores.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INTRO;
      x         <= X_CTR;
      y         <= Y_CTR;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      lscore    <= '0;
      rscore    <= '0;
      score_evt <= 1'b0;
      hold      <= '0;
      start_q   <= 1'b0;
    end else begin
      start_q   <= start_btn;
      score_evt <= 1'b0;
      case (state)
        ST_INTRO: begin
          if (start_rise) begin
            state  <= ST_SERVE;
            lscore <= '0;
            rscore <= '0;
            x      <= X_CTR;
            y      <= Y_CTR;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
            hold   <= '0;
          end
        end
        ST_SERVE: begin
          if (mv) begin
            if (hold == HOLD_LAST) begin
              hold  <= '0;
              state <= ST_PLAY;
            end else begin
              hold <= hold + 8'd1;
            end
          end
        end
        ST_PLAY: begin
          if (mv) begin
            if (l_miss) begin
              rscore    <= rscore + 7'd1;
              score_evt <= 1'b1;
              x         <= X_CTR;
              y         <= Y_CTR;
              dx_neg    <= 1'b1;
              dy_neg    <= dy_nxt;
              hold      <= '0;
              state     <= ((rscore + 7'd1) == WIN7) ? ST_END : ST_SERVE;
            end else if (r_miss) begin
              lscore    <= lscore + 7'd1;
              score_evt <= 1'b1;
              x         <= X_CTR;
              y         <= Y_CTR;
              dx_neg    <= 1'b0;
              dy_neg    <= dy_nxt;
              hold      <= '0;
              state     <= ((lscore + 7'd1) == WIN7) ? ST_END : ST_SERVE;
            end else begin
              x      <= x_step;
              y      <= y_step;
              dx_neg <= dx_nxt;
              dy_neg <= dy_nxt;
            end
          end
        end
        default: begin
          if (start_rise) state <= ST_INTRO;
        end
      endcase
    end
  end

endmodule
